// File: rtl/mem_responder.sv
// Memory-side responder: single outstanding request, fixed wait-state latency,
// little-endian word array with byte/half/word stores and error flagging.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, next_state;

    logic [3:0]        cnt;
    logic              lat_we;
    logic [1:0]        lat_size;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    logic              acc_we;
    logic [1:0]        acc_size;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_err;
    logic [IDX_W-1:0]  acc_idx;
    logic              accept;
    logic              enter_resp;
    logic              mem_we;
    logic [3:0]        be;
    logic [31:0]       wd;

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd1) next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
    end

    assign accept     = (state == IDLE) && req_valid;
    assign enter_resp = (next_state == RESP) && (state != RESP);

    // With LATENCY==1 the access happens on the accept edge, before the latches load.
    always_comb begin
        acc_we    = (state == IDLE) ? req_we    : lat_we;
        acc_size  = (state == IDLE) ? req_size  : lat_size;
        acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
        acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
        acc_idx   = acc_addr[IDX_W+1:2];
        acc_err   = (acc_size == 2'b11)
                 || (acc_size == 2'b01 && acc_addr[0])
                 || (acc_size == 2'b00 && acc_addr[1:0] != 2'b00)
                 || ({1'b0, acc_addr} >= ADDR_LIMIT);
    end

    always_comb begin
        be = '0;
        wd = acc_wdata;
        case (acc_size)
            2'b00: be = 4'b1111;
            2'b01: begin
                be = acc_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{acc_wdata[15:0]}};
            end
            2'b10: begin
                be = 4'b0001 << acc_addr[1:0];
                wd = {4{acc_wdata[7:0]}};
            end
            default: be = '0;
        endcase
    end

    assign mem_we = reset && enter_resp && acc_we && !acc_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[acc_idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_size   <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_size  <= req_size;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                cnt       <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                resp_err   <= acc_err;
                resp_rdata <= (acc_we || acc_err) ? '0 : mem[acc_idx];
            end else if (state == RESP && resp_ready) begin
                resp_err   <= 1'b0;
                resp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: LATENCY=2 instance (9-bit address so the
// out-of-range boundary is reachable) and a LATENCY=1 instance for streaming.
module tb_mem_responder;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
    logic [1:0]  a_req_size;
    logic [8:0]  a_req_addr;
    logic [31:0] a_req_wdata, a_resp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
    logic [1:0]  b_req_size;
    logic [7:0]  b_req_addr;
    logic [31:0] b_req_wdata, b_resp_rdata;

    mem_responder #(.ADDR_W(9), .DEPTH_WORDS(64), .LATENCY(2)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_size(a_req_size), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    mem_responder #(.ADDR_W(8), .DEPTH_WORDS(64), .LATENCY(1)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_size(b_req_size), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    logic [32:0] exp_a[$];
    logic [32:0] exp_b[$];
    logic [31:0] mdl_a [64];
    logic [31:0] mdl_b [16];

    function automatic logic model_err(input logic [1:0] size, input int unsigned addr);
        return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0)
            || (size == 2'd0 && addr % 4 != 0) || (addr >= 256);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] size,
                                          input int unsigned addr, input logic [31:0] wdata);
        logic [31:0] w;
        int unsigned n;
        w = old;
        n = (size == 2'd2) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int unsigned k = 0; k < n; k++) w[8*(addr % 4 + k) +: 8] = wdata[8*k +: 8];
        return w;
    endfunction

    always @(negedge clk) begin
        logic [32:0] e;
        if (a_resp_valid && a_resp_ready) begin
            vectors++;
            if (exp_a.size() == 0) begin
                miscompares++;
                $display("FAIL a_unexpected_resp: got err=%b rdata=%h, none pending", a_resp_err, a_resp_rdata);
            end else begin
                e = exp_a.pop_front();
                if ({a_resp_err, a_resp_rdata} !== e) begin
                    miscompares++;
                    $display("FAIL a_resp: got err=%b rdata=%h, want err=%b rdata=%h",
                             a_resp_err, a_resp_rdata, e[32], e[31:0]);
                end
            end
        end
        if (b_resp_valid && b_resp_ready) begin
            vectors++;
            if (exp_b.size() == 0) begin
                miscompares++;
                $display("FAIL b_unexpected_resp: got err=%b rdata=%h, none pending", b_resp_err, b_resp_rdata);
            end else begin
                e = exp_b.pop_front();
                if ({b_resp_err, b_resp_rdata} !== e) begin
                    miscompares++;
                    $display("FAIL b_resp: got err=%b rdata=%h, want err=%b rdata=%h",
                             b_resp_err, b_resp_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic a_xact(input logic we, input logic [1:0] size, input logic [8:0] addr,
                          input logic [31:0] wdata, output int lat);
        logic err;
        int   guard;
        err = model_err(size, addr);
        exp_a.push_back({err, (we || err) ? 32'h0 : mdl_a[addr[7:2]]});
        if (we && !err) mdl_a[addr[7:2]] = merge(mdl_a[addr[7:2]], size, addr, wdata);
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = we; a_req_size = size; a_req_addr = addr; a_req_wdata = wdata;
        guard = 0;
        while (!a_req_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        lat = 1;
        while (!a_resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        guard = 0;
        while (a_resp_valid && guard < 50) begin @(posedge clk); #1; guard++; end
        if (guard >= 50 || lat >= 50) begin
            vectors++; miscompares++;
            $display("FAIL a_timeout: lat=%0d guard=%0d, want bounded handshake", lat, guard);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors += 8;
        if (a_req_ready !== 1'b1)  begin miscompares++; $display("FAIL rst_a_req_ready: got %b want 1", a_req_ready); end
        if (a_resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_a_resp_valid: got %b want 0", a_resp_valid); end
        if (a_resp_rdata !== '0)   begin miscompares++; $display("FAIL rst_a_rdata: got %h want 0", a_resp_rdata); end
        if (a_resp_err !== 1'b0)   begin miscompares++; $display("FAIL rst_a_err: got %b want 0", a_resp_err); end
        if (b_req_ready !== 1'b1)  begin miscompares++; $display("FAIL rst_b_req_ready: got %b want 1", b_req_ready); end
        if (b_resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_b_resp_valid: got %b want 0", b_resp_valid); end
        if (b_resp_rdata !== '0)   begin miscompares++; $display("FAIL rst_b_rdata: got %h want 0", b_resp_rdata); end
        if (b_resp_err !== 1'b0)   begin miscompares++; $display("FAIL rst_b_err: got %b want 0", b_resp_err); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat;
        a_xact(1'b1, 2'd0, 9'h010, 32'hDEADBEEF, lat);
        vectors++;
        if (lat !== 2) begin miscompares++; $display("FAIL write_latency: got %0d want 2", lat); end
        a_xact(1'b0, 2'd0, 9'h010, 32'h0, lat);
        vectors++;
        if (lat !== 2) begin miscompares++; $display("FAIL read_latency: got %0d want 2", lat); end
    endtask

    task automatic test_lanes();
        int lat;
        a_xact(1'b1, 2'd2, 9'h011, 32'h5555_55AA, lat);
        a_xact(1'b1, 2'd1, 9'h012, 32'h9999_1234, lat);
        a_xact(1'b0, 2'd0, 9'h010, 32'h0, lat);
        a_xact(1'b0, 2'd1, 9'h012, 32'h0, lat);
        a_xact(1'b0, 2'd2, 9'h013, 32'h0, lat);
    endtask

    task automatic test_errors();
        int lat;
        a_xact(1'b1, 2'd0, 9'h004, 32'h0BAD_F00D, lat);
        a_xact(1'b1, 2'd1, 9'h013, 32'hFFFF_FFFF, lat);
        a_xact(1'b1, 2'd0, 9'h006, 32'hFFFF_FFFF, lat);
        a_xact(1'b1, 2'd3, 9'h010, 32'hFFFF_FFFF, lat);
        a_xact(1'b0, 2'd0, 9'h100, 32'h0, lat);
        vectors++;
        if (lat !== 2) begin miscompares++; $display("FAIL err_latency: got %0d want 2", lat); end
        a_xact(1'b0, 2'd0, 9'h006, 32'h0, lat);
        a_xact(1'b1, 2'd2, 9'h1FF, 32'hFFFF_FFFF, lat);
        a_xact(1'b0, 2'd0, 9'h010, 32'h0, lat);
        a_xact(1'b0, 2'd0, 9'h004, 32'h0, lat);
        a_xact(1'b0, 2'd0, 9'h0FC, 32'h0, lat);
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        int guard;
        int lat;
        exp = mdl_a[4];
        exp_a.push_back({1'b0, exp});
        @(posedge clk); #1;
        a_resp_ready = 1'b0;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_size = 2'd0; a_req_addr = 9'h010; a_req_wdata = '0;
        guard = 0;
        while (!a_req_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        guard = 0;
        while (!a_resp_valid && guard < 50) begin @(posedge clk); #1; guard++; end
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 9'h010; a_req_wdata = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            vectors += 3;
            if (a_resp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b want 1", c, a_resp_valid); end
            if ({a_resp_err, a_resp_rdata} !== {1'b0, exp}) begin
                miscompares++; $display("FAIL bp_hold[%0d]: got err=%b rdata=%h want err=0 rdata=%h", c, a_resp_err, a_resp_rdata, exp);
            end
            if (a_req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready[%0d]: got %b want 0", c, a_req_ready); end
        end
        a_req_valid = 1'b0;
        a_resp_ready = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (a_resp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release[%0d]: got valid %b want 0", c, a_resp_valid); end
            @(posedge clk); #1;
        end
        a_xact(1'b0, 2'd0, 9'h010, 32'h0, lat);
    endtask

    task automatic test_reset_in_wait();
        int lat;
        int guard;
        a_xact(1'b1, 2'd0, 9'h020, 32'hCAFE_F00D, lat);
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_size = 2'd0; a_req_addr = 9'h020; a_req_wdata = 32'h55;
        guard = 0;
        while (!a_req_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        vectors += 4;
        if (a_req_ready !== 1'b1)  begin miscompares++; $display("FAIL rstw_req_ready: got %b want 1", a_req_ready); end
        if (a_resp_valid !== 1'b0) begin miscompares++; $display("FAIL rstw_resp_valid: got %b want 0", a_resp_valid); end
        if (a_resp_rdata !== '0)   begin miscompares++; $display("FAIL rstw_rdata: got %h want 0", a_resp_rdata); end
        if (a_resp_err !== 1'b0)   begin miscompares++; $display("FAIL rstw_err: got %b want 0", a_resp_err); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        a_xact(1'b0, 2'd0, 9'h020, 32'h0, lat);
    endtask

    task automatic test_back_to_back();
        int acc [16];
        int guard;
        logic [31:0] d;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            b_req_valid = 1'b1;
            for (int i = 0; i < 16; i++) begin
                b_req_we = (pass == 0); b_req_size = 2'd0; b_req_addr = 8'(4 * i);
                if (pass == 0) begin
                    d = $urandom;
                    b_req_wdata = d; mdl_b[i] = d;
                    exp_b.push_back({1'b0, 32'h0});
                end else begin
                    b_req_wdata = '0;
                    exp_b.push_back({1'b0, mdl_b[i]});
                end
                guard = 0;
                while (!b_req_ready && guard < 50) begin @(negedge clk); guard++; end
                @(posedge clk); #1;
                acc[i] = cyc;
            end
            b_req_valid = 1'b0;
            guard = 0;
            while (exp_b.size() != 0 && guard < 20) begin @(posedge clk); #1; guard++; end
            if (pass == 1) begin
                for (int i = 1; i < 16; i++) begin
                    vectors++;
                    if (acc[i] - acc[i-1] !== 2) begin
                        miscompares++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want 2", i, acc[i] - acc[i-1]);
                    end
                end
            end
        end
    endtask

    initial begin
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_size = '0; a_req_addr = '0; a_req_wdata = '0; a_resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = '0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b1;
        test_reset();
        test_basic();
        test_lanes();
        test_errors();
        test_backpressure();
        test_reset_in_wait();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (exp_a.size() + exp_b.size() != 0) begin
            miscompares++; $display("FAIL drain: got %0d/%0d pending responses want 0", exp_a.size(), exp_b.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
